seq_lock_timer: RTL

// Parametrised sequential combination lock with a timed entry window, failed-attempt lockout and auto-relock.

---
 rtl/lock_pkg.sv | 37 +++
 rtl/bcd_down_timer.sv | 51 +++++
 rtl/seq_lock_timer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared encodings and helpers for the sequential combination lock.
package lock_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StArmed   = ARMED,
    StOpen    = OPEN,
    StLockout = LOCKOUT
  } state_e;

  // Active-low segments a..g, a in the MSB; non-decimal codes render as 0.
  function automatic logic [6:0] seg7_dec(input logic [3:0] bcd);
    case (bcd)
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  // Two-digit BCD {tens, units} of a value in 0..99.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down counter stepped by a free-running one-second tick divider.
module bcd_down_timer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter logic [7:0]  RESET_VAL = 8'h60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec_en,
  output logic       tick,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       zero
);

  localparam int unsigned   DivW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_HZ - 1);

  logic [DivW-1:0] div_q;
  logic [3:0]      tens_q, units_q;

  assign tick  = (div_q == DivMax);
  assign zero  = (tens_q == 4'd0) && (units_q == 4'd0);
  assign tens  = tens_q;
  assign units = units_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      tens_q  <= RESET_VAL[7:4];
      units_q <= RESET_VAL[3:0];
    end else if (load) begin
      div_q   <= '0;
      tens_q  <= load_val[7:4];
      units_q <= load_val[3:0];
    end else begin
      div_q <= tick ? '0 : div_q + DivW'(1);
      // Saturates at 00; the owner decides what expiry means.
      if (tick && dec_en && !zero) begin
        if (units_q == 4'd0) begin
          units_q <= 4'd9;
          tens_q  <= tens_q - 4'd1;
        end else begin
          units_q <= units_q - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_lock_timer.sv
// Sequential combination lock with timed entry window, failed-attempt lockout,
// auto-relock and a two-digit multiplexed seven-segment countdown.
module seq_lock_timer
  import lock_pkg::*;
#(
  parameter int unsigned                SW_W      = 3,
  parameter int unsigned                CODE_LEN  = 4,
  parameter logic [CODE_LEN*SW_W-1:0]   CODE      = 12'b010_110_111_011,
  parameter int unsigned                CLK_HZ    = 50_000_000,
  parameter int unsigned                SCAN_DIV  = 25_000,
  parameter int unsigned                TIMEOUT_S = 60,
  parameter int unsigned                RELOCK_S  = 30,
  parameter int unsigned                MAX_FAILS = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             pb,
  input  logic [SW_W-1:0]                  x,
  output logic                             lock_open,
  output logic                             lock_closed,
  output logic [$clog2(CODE_LEN+1)-1:0]    step_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic                             lockout,
  output logic [6:0]                       sevseg,
  output logic [3:0]                       an
);

  localparam int unsigned       StepW      = $clog2(CODE_LEN + 1);
  localparam int unsigned       FailW      = $clog2(MAX_FAILS + 1);
  localparam logic [StepW-1:0]  StepDone   = StepW'(CODE_LEN);
  localparam logic [FailW-1:0]  FailMax    = FailW'(MAX_FAILS);
  localparam logic [7:0]        TimeoutBcd = to_bcd(TIMEOUT_S);
  localparam logic [7:0]        RelockBcd  = to_bcd(RELOCK_S);
  localparam int unsigned       ScanW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanMax    = ScanW'(SCAN_DIV - 1);

  function automatic logic [SW_W-1:0] code_at(input int unsigned i);
    int unsigned k;
    k = (i < CODE_LEN) ? i : 0;
    return CODE[(CODE_LEN-1-k)*SW_W +: SW_W];
  endfunction

  state_e            state_q, state_d;
  logic [StepW-1:0]  step_q, step_d, step_next;
  logic [FailW-1:0]  fail_q, fail_d, fail_inc;
  logic              lockout_d;
  logic              pb_s1, pb_s2, pb_prev, pb_evt;
  logic [SW_W-1:0]   x_s1, x_s2, x_prev;
  logic              x_evt;
  logic              tmr_load, tmr_dec, tick, tmr_zero;
  logic [7:0]        tmr_val;
  logic [3:0]        tmr_tens, tmr_units, disp_tens, disp_units;
  logic [ScanW-1:0]  scan_q;
  logic              sel_q, scan_tc;

  assign step_idx = step_q;
  assign fail_cnt = fail_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pb_s1   <= 1'b0;
      pb_s2   <= 1'b0;
      pb_prev <= 1'b0;
      x_s1    <= '0;
      x_s2    <= '0;
      x_prev  <= '0;
    end else begin
      pb_s1   <= pb;
      pb_s2   <= pb_s1;
      pb_prev <= pb_s2;
      x_s1    <= x;
      x_s2    <= x_s1;
      x_prev  <= x_s2;
    end
  end

  assign pb_evt   = pb_s2 & ~pb_prev;
  assign x_evt    = (x_s2 != x_prev);
  assign fail_inc = fail_q + FailW'(1);

  // A wrong entry that happens to be the first code digit restarts the sequence at 1.
  always_comb begin
    step_next = '0;
    if (x_s2 == code_at(32'(step_q))) begin
      step_next = step_q + StepW'(1);
    end else if (x_s2 == code_at(0)) begin
      step_next = StepW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    fail_d    = fail_q;
    lockout_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = TimeoutBcd;
    tmr_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmr_load = 1'b1;
        if (pb_evt) begin
          state_d = StArmed;
          step_d  = '0;
        end
      end
      StArmed: begin
        tmr_dec = 1'b1;
        if (step_q == StepDone) begin
          state_d  = StOpen;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = RelockBcd;
        end else if (x_evt && step_next == StepDone) begin
          step_d = step_next;
        end else if (tick && tmr_zero) begin
          fail_d = fail_inc;
          step_d = '0;
          if (fail_inc == FailMax) begin
            state_d   = StLockout;
            lockout_d = 1'b1;
          end else begin
            state_d  = StIdle;
            tmr_load = 1'b1;
          end
        end else if (pb_evt) begin
          state_d  = StIdle;
          step_d   = '0;
          tmr_load = 1'b1;
        end else if (x_evt) begin
          step_d = step_next;
        end
      end
      StOpen: begin
        tmr_dec = 1'b1;
        if (pb_evt || (tick && tmr_zero)) begin
          state_d  = StIdle;
          step_d   = '0;
          tmr_load = 1'b1;
        end
      end
      StLockout: begin
        lockout_d = tick ? ~lockout : lockout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      fail_q      <= '0;
      lock_open   <= 1'b0;
      lock_closed <= 1'b1;
      lockout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      fail_q      <= fail_d;
      lock_open   <= (state_d == StOpen);
      lock_closed <= (state_d != StOpen);
      lockout     <= lockout_d;
    end
  end

  bcd_down_timer #(
    .CLK_HZ    (CLK_HZ),
    .RESET_VAL (TimeoutBcd)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec_en   (tmr_dec),
    .tick     (tick),
    .tens     (tmr_tens),
    .units    (tmr_units),
    .zero     (tmr_zero)
  );

  assign disp_tens  = (state_q == StLockout) ? 4'd0 : tmr_tens;
  assign disp_units = (state_q == StLockout) ? 4'd0 : tmr_units;
  assign scan_tc    = (scan_q == ScanMax);

  // Segments only refresh together with the digit enable so the two never disagree.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      sel_q  <= 1'b0;
      an     <= 4'b1110;
      sevseg <= 7'b1111111;
    end else begin
      scan_q <= scan_tc ? '0 : scan_q + ScanW'(1);
      if (scan_tc) begin
        sel_q  <= ~sel_q;
        an     <= sel_q ? 4'b1110 : 4'b1101;
        sevseg <= seg7_dec(sel_q ? disp_units : disp_tens);
      end
    end
  end

endmodule
